// File: rtl/pipe_pkg.sv
// Shared types for the generic pipeline stage register.
// Stage priority on every edge is reset > stall > flush > normal.
package pipe_pkg;

  typedef logic [1:0] occ_t;

  typedef enum logic [1:0] {
    PRI_RESET  = 2'd0,
    PRI_STALL  = 2'd1,
    PRI_FLUSH  = 2'd2,
    PRI_NORMAL = 2'd3
  } pri_e;

  // Reset/flush values; payload and control vectors are zeroed with '0
  localparam logic VALID_ZERO = 1'b0;
  localparam occ_t OCC_EMPTY  = 2'd0;

  // Resolve the control inputs to the single action taken this edge
  function automatic pri_e stage_pri(input logic rst, input logic stall,
                                     input logic flush);
    if (rst)        return PRI_RESET;
    else if (stall) return PRI_STALL;
    else if (flush) return PRI_FLUSH;
    else            return PRI_NORMAL;
  endfunction

endpackage

// File: rtl/pipe_slot.sv
// One storage entry (valid, payload, control) of the stage register.
// clr zeroes the entry, ld captures a new beat, inv only drops valid.
module pipe_slot
  import pipe_pkg::*;
#(
  parameter int DATA_W = 96,
  parameter int CTRL_W = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              clr_i,
  input  logic              ld_i,
  input  logic              inv_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic [CTRL_W-1:0] ctrl_i,
  output logic              valid_o,
  output logic [DATA_W-1:0] data_o,
  output logic [CTRL_W-1:0] ctrl_o
);

  logic              valid_q, valid_d;
  logic [DATA_W-1:0] data_q,  data_d;
  logic [CTRL_W-1:0] ctrl_q,  ctrl_d;

  // Next entry contents: clear beats load, load beats invalidate
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    ctrl_d  = ctrl_q;
    if (clr_i) begin
      valid_d = VALID_ZERO;
      data_d  = '0;
      ctrl_d  = '0;
    end else if (ld_i) begin
      valid_d = 1'b1;
      data_d  = data_i;
      ctrl_d  = ctrl_i;
    end else if (inv_i) begin
      valid_d = VALID_ZERO;
    end
  end

  // Entry register with synchronous reset to the zero beat
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= VALID_ZERO;
      data_q  <= '0;
      ctrl_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      ctrl_q  <= ctrl_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign ctrl_o  = ctrl_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Generic valid/ready pipeline stage register with stall and flush.
// Define PIPE_STAGE_SKID_EN for a 2-entry skid buffer with a ready that
// comes from registers only; otherwise a single entry whose ready passes
// i_ready through combinationally.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int DATA_W = 96,
  parameter int CTRL_W = 8
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [DATA_W-1:0] i_data,
  input  logic [CTRL_W-1:0] i_ctrl,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [DATA_W-1:0] o_data,
  output logic [CTRL_W-1:0] o_ctrl,
  input  logic              i_stall,
  input  logic              i_flush,
  output occ_t              o_occupancy
);

  pri_e              pri;
  logic              norm, clr;
  logic              in_fire, out_fire;
  logic              main_v, main_ld, main_inv;
  logic [DATA_W-1:0] main_data, main_ld_data;
  logic [CTRL_W-1:0] main_ctrl, main_ld_ctrl;

  assign pri  = stage_pri(i_rst, i_stall, i_flush);
  assign norm = (pri == PRI_NORMAL);
  assign clr  = (pri == PRI_FLUSH);

  // Stall and reset mask the handshake on both sides
  assign o_valid  = main_v & ~i_rst & ~i_stall;
  assign in_fire  = i_valid & o_ready;
  assign out_fire = o_valid & i_ready;
  assign o_data   = main_data;
  assign o_ctrl   = main_ctrl;

  pipe_slot #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_main (
    .clk_i(i_clk), .rst_i(i_rst), .clr_i(clr), .ld_i(main_ld), .inv_i(main_inv),
    .data_i(main_ld_data), .ctrl_i(main_ld_ctrl),
    .valid_o(main_v), .data_o(main_data), .ctrl_o(main_ctrl)
  );

`ifdef PIPE_STAGE_SKID_EN
  logic              skid_v, skid_ld, skid_inv;
  logic [DATA_W-1:0] skid_data;
  logic [CTRL_W-1:0] skid_ctrl;

  assign o_ready = ~i_rst & ~i_stall & ~skid_v;

  // Move beats between upstream, skid and main keeping FIFO order
  always_comb begin
    main_ld      = 1'b0;
    main_inv     = 1'b0;
    skid_ld      = 1'b0;
    skid_inv     = 1'b0;
    main_ld_data = i_data;
    main_ld_ctrl = i_ctrl;
    if (norm) begin
      if (out_fire) begin
        if (skid_v) begin
          main_ld      = 1'b1;
          main_ld_data = skid_data;
          main_ld_ctrl = skid_ctrl;
          skid_inv     = 1'b1;
        end else if (in_fire) begin
          main_ld = 1'b1;
        end else begin
          main_inv = 1'b1;
        end
      end else if (in_fire) begin
        if (main_v) skid_ld = 1'b1;
        else        main_ld = 1'b1;
      end
    end
  end

  pipe_slot #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_skid (
    .clk_i(i_clk), .rst_i(i_rst), .clr_i(clr), .ld_i(skid_ld), .inv_i(skid_inv),
    .data_i(i_data), .ctrl_i(i_ctrl),
    .valid_o(skid_v), .data_o(skid_data), .ctrl_o(skid_ctrl)
  );

  assign o_occupancy = {1'b0, main_v} + {1'b0, skid_v};
`else
  // A full entry can still accept when downstream drains it this cycle
  assign o_ready = ~i_rst & ~i_stall & (~main_v | i_ready);

  // Single entry: load on accept, empty when drained with nothing behind
  always_comb begin
    main_ld      = norm & in_fire;
    main_inv     = norm & out_fire & ~in_fire;
    main_ld_data = i_data;
    main_ld_ctrl = i_ctrl;
  end

  assign o_occupancy = {1'b0, main_v};
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: a queue model of the stage is checked against
// the DUT every cycle; directed literal checks pin the model.
module tb_pipe_stage_reg;
  import pipe_pkg::*;

  localparam int DW = 96;
  localparam int CW = 8;
`ifdef PIPE_STAGE_SKID_EN
  localparam int CAP = 2;
`else
  localparam int CAP = 1;
`endif

  logic          clk;
  logic          rst, valid, rdy, stall, flush;
  int            vid;
  logic [DW-1:0] i_data, o_data;
  logic [CW-1:0] i_ctrl, o_ctrl;
  logic          o_ready, o_valid;
  occ_t          occ;

  int checks = 0;
  int errors = 0;
  int q[$];

  function automatic logic [DW-1:0] mk_data(input int v);
    return {32'h5EED0000 | 32'(v), 32'(v * 3), 32'(v)};
  endfunction
  function automatic logic [CW-1:0] mk_ctrl(input int v);
    return 8'(v) ^ 8'hC3;
  endfunction

  assign i_data = mk_data(vid);
  assign i_ctrl = mk_ctrl(vid);

  pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW)) dut (
    .i_clk(clk), .i_rst(rst), .i_valid(valid), .o_ready(o_ready),
    .i_data(i_data), .i_ctrl(i_ctrl), .o_valid(o_valid), .i_ready(rdy),
    .o_data(o_data), .o_ctrl(o_ctrl), .i_stall(stall), .i_flush(flush),
    .o_occupancy(occ)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [DW-1:0] act,
                     input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Model: compare then advance the queue at each falling edge
  always @(negedge clk) begin
    logic exp_ready, exp_valid, inf, outf;
    exp_valid = !rst && !stall && q.size() > 0;
`ifdef PIPE_STAGE_SKID_EN
    exp_ready = !rst && !stall && q.size() < CAP;
`else
    exp_ready = !rst && !stall && (q.size() == 0 || rdy);
`endif
    chk("m_valid", DW'(o_valid), DW'(exp_valid));
    chk("m_ready", DW'(o_ready), DW'(exp_ready));
    chk("m_occ",   DW'(occ),     DW'(q.size()));
    if (q.size() > 0) begin
      chk("m_data", o_data, mk_data(q[0]));
      chk("m_ctrl", DW'(o_ctrl), DW'(mk_ctrl(q[0])));
    end
    if (rst) q.delete();
    else if (!stall) begin
      inf  = valid && exp_ready;
      outf = exp_valid && rdy;
      if (flush) q.delete();
      else begin
        if (outf) void'(q.pop_front());
        if (inf) q.push_back(vid);
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int  v;
    logic acc;
    rst = 1; valid = 0; rdy = 1; stall = 0; flush = 0; vid = 1;
    cyc(2);
    chk("rst_valid", DW'(o_valid), '0);
    chk("rst_ready", DW'(o_ready), '0);
    chk("rst_data",  o_data, '0);
    chk("rst_ctrl",  DW'(o_ctrl), '0);
    chk("rst_occ",   DW'(occ), '0);
    rst = 0;

    // Streaming: each beat visible one cycle after its accept
    for (int k = 1; k <= 8; k++) begin
      vid = k; valid = 1;
      cyc(1);
      chk("str_data", o_data, mk_data(k));
      chk("str_valid", DW'(o_valid), DW'(1));
      chk("str_occ", DW'(occ), DW'(1));
    end
    valid = 0;
    cyc(1);
    chk("str_drain_occ", DW'(occ), '0);

`ifdef PIPE_STAGE_SKID_EN
    // Back-pressure fills both entries, 0xC waits upstream
    rdy = 0; valid = 1; vid = 'hA; cyc(1);
    vid = 'hB; cyc(1);
    vid = 'hC; cyc(2);
    chk("skid_occ2", DW'(occ), DW'(2));
    chk("skid_ready0", DW'(o_ready), '0);
    chk("skid_headA", o_data, mk_data('hA));
    stall = 1; cyc(3);
    chk("stall_valid", DW'(o_valid), '0);
    chk("stall_ready", DW'(o_ready), '0);
    chk("stall_occ", DW'(occ), DW'(2));
    chk("stall_head", o_data, mk_data('hA));
    stall = 0; #1;
    chk("unstall_valid", DW'(o_valid), DW'(1));
    rdy = 1; cyc(1);
    chk("rel_headB", o_data, mk_data('hB));
    chk("rel_ready", DW'(o_ready), DW'(1));
    cyc(1);
    valid = 0; cyc(2);
    // Flush at occupancy 2 while 0xD is offered
    rdy = 0; valid = 1; vid = 1; cyc(1);
    vid = 2; cyc(1);
    vid = 'hD; flush = 1; cyc(1);
    flush = 0; valid = 0;
    chk("fl2_valid", DW'(o_valid), '0);
    chk("fl2_ctrl", DW'(o_ctrl), '0);
    chk("fl2_occ", DW'(occ), '0);
    cyc(2);
`endif

    // Flush while 0xD actually fires in
    rdy = 1; valid = 1; vid = 3; cyc(1);
    vid = 'hD; flush = 1; cyc(1);
    flush = 0; valid = 0;
    chk("fl_valid", DW'(o_valid), '0);
    chk("fl_occ", DW'(occ), '0);
    chk("fl_data", o_data, '0);
    chk("fl_ctrl", DW'(o_ctrl), '0);
    cyc(2);

    // Stall and flush together: stall wins, then flush alone clears
    rdy = 0; valid = 1; vid = 5; cyc(1);
    valid = 0; stall = 1; flush = 1; cyc(1);
    chk("sf_occ", DW'(occ), DW'(1));
    chk("sf_data", o_data, mk_data(5));
    stall = 0; cyc(1);
    chk("f_occ", DW'(occ), '0);
    chk("f_ctrl", DW'(o_ctrl), '0);
    flush = 0; cyc(1);

    // Continuous upstream with toggling downstream ready
    v = 6; vid = v; valid = 1;
    for (int k = 0; k < 10; k++) begin
      rdy = (k % 2 == 0) ? 1'b0 : 1'b1;
      #1;
`ifndef PIPE_STAGE_SKID_EN
      if (occ == 2'd1) chk("tog_ready", DW'(o_ready), DW'(rdy));
`endif
      acc = o_ready;
      cyc(1);
      if (acc) begin v++; vid = v; end
    end
    valid = 0; rdy = 1; cyc(3);
    chk("tog_drain_occ", DW'(occ), '0);

    // Reset with a beat held
    rdy = 0; valid = 1; vid = 'h20; cyc(1);
    valid = 0; rst = 1; cyc(1);
    chk("mrst_valid", DW'(o_valid), '0);
    chk("mrst_data", o_data, '0);
    chk("mrst_ctrl", DW'(o_ctrl), '0);
    chk("mrst_occ", DW'(occ), '0);
    rst = 0; rdy = 1; cyc(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
